// File: rtl/rob_pkg.sv
// Shared constants and entry layout for the Tomasulo reorder buffer.
// ROB_CDB_FWD_EN selects same-cycle CDB forwarding on the query ports.
package rob_pkg;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = $clog2(DEPTH);
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic              is_br;
        logic              mispredict;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] target;
    } rob_entry_t;

    // DEPTH is a power of two, so the natural tag overflow is the ring wrap.
    function automatic tag_t tag_inc(input tag_t t);
        return t + tag_t'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / query / commit / flush bundle between the core and the reorder buffer.
// The core side uses the master modport, the buffer uses the slave modport.
interface reorder_buffer_if;
    import rob_pkg::*;

    logic                issue_valid;
    logic [RD_W-1:0]     issue_rd;
    logic                issue_is_br;
    tag_t                issue_tag;
    logic                rob_full;
    logic                rob_empty;

    logic                cdb_valid;
    tag_t                cdb_tag;
    logic [DATA_W-1:0]   cdb_val;
    logic                cdb_mispredict;
    logic [DATA_W-1:0]   cdb_target;

    tag_t                query_tag_1;
    tag_t                query_tag_2;
    logic                query_ready_1;
    logic                query_ready_2;
    logic [DATA_W-1:0]   query_val_1;
    logic [DATA_W-1:0]   query_val_2;

    logic                commit_valid;
    logic [RD_W-1:0]     commit_rd;
    logic [DATA_W-1:0]   commit_val;
    tag_t                commit_tag;
    logic                flush_out;
    logic [DATA_W-1:0]   flush_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_br,
        output cdb_valid, cdb_tag, cdb_val, cdb_mispredict, cdb_target,
        output query_tag_1, query_tag_2,
        input  issue_tag, rob_full, rob_empty,
        input  query_ready_1, query_ready_2, query_val_1, query_val_2,
        input  commit_valid, commit_rd, commit_val, commit_tag,
        input  flush_out, flush_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_br,
        input  cdb_valid, cdb_tag, cdb_val, cdb_mispredict, cdb_target,
        input  query_tag_1, query_tag_2,
        output issue_tag, rob_full, rob_empty,
        output query_ready_1, query_ready_2, query_val_1, query_val_2,
        output commit_valid, commit_rd, commit_val, commit_tag,
        output flush_out, flush_pc
    );

endinterface

// File: rtl/rob_entry_array.sv
// Reorder-buffer entry storage: allocate port, CDB write port, head read, two query ports, clear-all.
// With ROB_CDB_FWD_EN defined the query ports see a same-cycle CDB result.
module rob_entry_array
    import rob_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              alloc_en_i,
    input  tag_t              alloc_tag_i,
    input  logic [RD_W-1:0]   alloc_rd_i,
    input  logic              alloc_is_br_i,
    input  logic              cdb_en_i,
    input  tag_t              cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_val_i,
    input  logic              cdb_mispredict_i,
    input  logic [DATA_W-1:0] cdb_target_i,
    input  logic              retire_en_i,
    input  tag_t              head_tag_i,
    output rob_entry_t        head_o,
    input  logic              clear_i,
    input  tag_t              qtag1_i,
    input  tag_t              qtag2_i,
    output logic              qready1_o,
    output logic [DATA_W-1:0] qval1_o,
    output logic              qready2_o,
    output logic [DATA_W-1:0] qval2_o
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [RD_W-1:0]   rd_q     [DEPTH];
    logic              is_br_q  [DEPTH];
    logic              mis_q    [DEPTH];
    logic [DATA_W-1:0] val_q    [DEPTH];
    logic [DATA_W-1:0] target_q [DEPTH];
    logic              cdb_hit;

    // Results for entries that were never allocated (or already flushed) are dropped.
    assign cdb_hit = cdb_en_i & valid_q[cdb_tag_i];

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        if (retire_en_i) begin
            valid_d[head_tag_i] = 1'b0;
        end
        if (alloc_en_i) begin
            valid_d[alloc_tag_i] = 1'b1;
            ready_d[alloc_tag_i] = 1'b0;
        end
        if (cdb_hit) begin
            ready_d[cdb_tag_i] = 1'b1;
        end
        if (clear_i) begin
            valid_d = '0;
            ready_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Payload fields are only meaningful behind valid/ready, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_en_i) begin
            rd_q[alloc_tag_i]    <= alloc_rd_i;
            is_br_q[alloc_tag_i] <= alloc_is_br_i;
            mis_q[alloc_tag_i]   <= 1'b0;
        end
        if (cdb_hit) begin
            val_q[cdb_tag_i]    <= cdb_val_i;
            target_q[cdb_tag_i] <= cdb_target_i;
            mis_q[cdb_tag_i]    <= cdb_mispredict_i & is_br_q[cdb_tag_i];
        end
    end

    always_comb begin
        head_o.valid      = valid_q[head_tag_i];
        head_o.ready      = ready_q[head_tag_i];
        head_o.is_br      = is_br_q[head_tag_i];
        head_o.mispredict = mis_q[head_tag_i];
        head_o.rd         = rd_q[head_tag_i];
        head_o.val        = val_q[head_tag_i];
        head_o.target     = target_q[head_tag_i];
    end

    always_comb begin
        qready1_o = valid_q[qtag1_i] & ready_q[qtag1_i];
        qval1_o   = val_q[qtag1_i];
        qready2_o = valid_q[qtag2_i] & ready_q[qtag2_i];
        qval2_o   = val_q[qtag2_i];
`ifdef ROB_CDB_FWD_EN
        if (cdb_hit && (cdb_tag_i == qtag1_i)) begin
            qready1_o = 1'b1;
            qval1_o   = cdb_val_i;
        end
        if (cdb_hit && (cdb_tag_i == qtag2_i)) begin
            qready2_o = 1'b1;
            qval2_o   = cdb_val_i;
        end
`endif
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, in-order commit, flush on mispredicted head.
// Optional ROB_CDB_FWD_EN enables same-cycle CDB forwarding on the query ports.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave rob
);

    localparam int CNT_W = TAG_W + 1;

    tag_t              head_q, head_d;
    tag_t              tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              commit_valid_q, commit_valid_d;
    logic [RD_W-1:0]   commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0] commit_val_q, commit_val_d;
    tag_t              commit_tag_q, commit_tag_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] flush_pc_q, flush_pc_d;

    rob_entry_t        head_entry;
    logic              full, empty;
    logic              issue_en, commit_en, flush_en, cdb_en;

    // Full/empty come from the registered count: a full buffer refuses issue even while committing.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign commit_en = rdy_in & head_entry.valid & head_entry.ready;
    assign flush_en  = commit_en & head_entry.is_br & head_entry.mispredict;
    assign issue_en  = rdy_in & rob.issue_valid & ~full & ~flush_en;
    assign cdb_en    = rdy_in & rob.cdb_valid & ~flush_en;

    rob_entry_array u_entries (
        .clk_i            (clk_in),
        .rst_n_i          (rst_in),
        .alloc_en_i       (issue_en),
        .alloc_tag_i      (tail_q),
        .alloc_rd_i       (rob.issue_rd),
        .alloc_is_br_i    (rob.issue_is_br),
        .cdb_en_i         (cdb_en),
        .cdb_tag_i        (rob.cdb_tag),
        .cdb_val_i        (rob.cdb_val),
        .cdb_mispredict_i (rob.cdb_mispredict),
        .cdb_target_i     (rob.cdb_target),
        .retire_en_i      (commit_en),
        .head_tag_i       (head_q),
        .head_o           (head_entry),
        .clear_i          (flush_en),
        .qtag1_i          (rob.query_tag_1),
        .qtag2_i          (rob.query_tag_2),
        .qready1_o        (rob.query_ready_1),
        .qval1_o          (rob.query_val_1),
        .qready2_o        (rob.query_ready_2),
        .qval2_o          (rob.query_val_2)
    );

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = commit_en;
        commit_rd_d    = commit_en ? head_entry.rd  : '0;
        commit_val_d   = commit_en ? head_entry.val : '0;
        commit_tag_d   = commit_en ? head_q         : '0;
        flush_d        = flush_en;
        flush_pc_d     = flush_en ? head_entry.target : '0;

        if (flush_en) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_en) begin
                tail_d = tag_inc(tail_q);
            end
            if (commit_en) begin
                head_d = tag_inc(head_q);
            end
            case ({issue_en, commit_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // rdy_in low freezes every register, including the registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy_in) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_tag_q   <= commit_tag_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    assign rob.issue_tag    = tail_q;
    assign rob.rob_full     = full;
    assign rob.rob_empty    = empty;
    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_val   = commit_val_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.flush_out    = flush_q;
    assign rob.flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; expectations follow ROB_CDB_FWD_EN when defined.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .rob    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_is_br    = 1'b0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_tag        = '0;
        bus.cdb_val        = '0;
        bus.cdb_mispredict = 1'b0;
        bus.cdb_target     = '0;
        bus.query_tag_1    = '0;
        bus.query_tag_2    = '0;
    endtask

    task automatic apply_reset();
        idle();
        rdy   = 1'b1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cdb(input int tag, input logic [31:0] val, input logic mis, input logic [31:0] tgt);
        bus.cdb_valid      = 1'b1;
        bus.cdb_tag        = tag_t'(tag);
        bus.cdb_val        = val;
        bus.cdb_mispredict = mis;
        bus.cdb_target     = tgt;
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'(5 + i);
            n_checks++;
            if (bus.issue_tag !== tag_t'(i)) begin
                n_fail++;
                $display("FAIL inorder_issue_tag%0d: got %0d expected %0d", i, bus.issue_tag, i);
            end
            tick();
        end
        idle();
        cdb(2, 32'h33, 1'b0, 32'h0);
        tick();
        cdb(0, 32'h11, 1'b0, 32'h0);
        tick();
        cdb(1, 32'h22, 1'b0, 32'h0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({bus.commit_valid, bus.commit_rd, bus.commit_val, bus.commit_tag} !==
                {1'b1, 5'(5 + k), 32'h11 * (k + 1), tag_t'(k)}) begin
                n_fail++;
                $display("FAIL inorder_commit%0d: got v=%0b rd=%0d val=%h tag=%0d expected rd=%0d val=%h tag=%0d",
                         k, bus.commit_valid, bus.commit_rd, bus.commit_val, bus.commit_tag,
                         5 + k, 32'h11 * (k + 1), k);
            end
            tick();
        end
        n_checks++;
        if ({bus.commit_valid, bus.commit_rd, bus.rob_empty} !== {1'b0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL inorder_drained: got v=%0b rd=%0d empty=%0b expected 0 0 1",
                     bus.commit_valid, bus.commit_rd, bus.rob_empty);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick();
        bus.issue_rd    = 5'd4;
        cdb(0, 32'h77, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        n_checks++;
        if (bus.commit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_precommit: got %0b expected 1", bus.commit_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.rob_empty, bus.rob_full, bus.commit_valid, bus.flush_out, bus.issue_tag} !==
            {1'b1, 1'b0, 1'b0, 1'b0, tag_t'(0)}) begin
            n_fail++;
            $display("FAIL reset_async: got empty=%0b full=%0b cv=%0b flush=%0b tag=%0d expected 1 0 0 0 0",
                     bus.rob_empty, bus.rob_full, bus.commit_valid, bus.flush_out, bus.issue_tag);
        end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'd1;
            n_checks++;
            if (bus.issue_tag !== tag_t'(i)) begin
                n_fail++;
                $display("FAIL full_issue_tag%0d: got %0d expected %0d", i, bus.issue_tag, i);
            end
            tick();
        end
        n_checks++;
        if ({bus.rob_full, bus.rob_empty} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_flag: got full=%0b empty=%0b expected 1 0", bus.rob_full, bus.rob_empty);
        end
        bus.issue_rd = 5'd9;
        tick();
        n_checks++;
        if ({bus.issue_tag, bus.rob_full} !== {tag_t'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL full_17th_ignored: got tag=%0d full=%0b expected 0 1", bus.issue_tag, bus.rob_full);
        end
        idle();
        cdb(0, 32'hA0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        n_checks++;
        if ({bus.commit_valid, bus.commit_tag, bus.commit_val, bus.rob_full} !== {1'b1, tag_t'(0), 32'hA0, 1'b0}) begin
            n_fail++;
            $display("FAIL full_commit_one: got cv=%0b tag=%0d val=%h full=%0b expected 1 0 a0 0",
                     bus.commit_valid, bus.commit_tag, bus.commit_val, bus.rob_full);
        end
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd2;
        n_checks++;
        if (bus.issue_tag !== tag_t'(0)) begin
            n_fail++;
            $display("FAIL wrap_tag: got %0d expected 0", bus.issue_tag);
        end
        tick();
        n_checks++;
        if ({bus.rob_full, bus.issue_tag} !== {1'b1, tag_t'(1)}) begin
            n_fail++;
            $display("FAIL wrap_refull: got full=%0b tag=%0d expected 1 1", bus.rob_full, bus.issue_tag);
        end
        idle();
        cdb(1, 32'hB1, 1'b0, 32'h0);
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick();
        idle();
        n_checks++;
        if ({bus.commit_valid, bus.commit_tag, bus.rob_full, bus.issue_tag} !==
            {1'b1, tag_t'(1), 1'b0, tag_t'(1)}) begin
            n_fail++;
            $display("FAIL full_reject_while_commit: got cv=%0b ctag=%0d full=%0b tag=%0d expected 1 1 0 1",
                     bus.commit_valid, bus.commit_tag, bus.rob_full, bus.issue_tag);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'(i);
            bus.issue_is_br = (i == 0);
            tick();
        end
        idle();
        for (int i = 1; i < 4; i++) begin
            cdb(i, 32'h50 + i, 1'b0, 32'h0);
            tick();
        end
        cdb(0, 32'h0, 1'b1, 32'h100);
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        tick();
        idle();
        n_checks++;
        if ({bus.commit_valid, bus.commit_tag, bus.commit_rd, bus.flush_out, bus.flush_pc, bus.rob_empty, bus.issue_tag} !==
            {1'b1, tag_t'(0), 5'd0, 1'b1, 32'h100, 1'b1, tag_t'(0)}) begin
            n_fail++;
            $display("FAIL flush_pulse: got cv=%0b ctag=%0d rd=%0d fl=%0b pc=%h empty=%0b tag=%0d expected 1 0 0 1 100 1 0",
                     bus.commit_valid, bus.commit_tag, bus.commit_rd, bus.flush_out, bus.flush_pc,
                     bus.rob_empty, bus.issue_tag);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.commit_valid, bus.flush_out, bus.rob_empty} !== 3'b001) begin
                n_fail++;
                $display("FAIL flush_no_commit%0d: got cv=%0b fl=%0b empty=%0b expected 0 0 1",
                         i, bus.commit_valid, bus.flush_out, bus.rob_empty);
            end
        end
    endtask

    task automatic test_query();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'(i + 1);
            tick();
        end
        idle();
        bus.query_tag_1 = tag_t'(3);
        bus.query_tag_2 = tag_t'(0);
        cdb(3, 32'hABCD, 1'b0, 32'h0);
        #1;
`ifdef ROB_CDB_FWD_EN
        n_checks++;
        if ({bus.query_ready_1, bus.query_val_1} !== {1'b1, 32'hABCD}) begin
            n_fail++;
            $display("FAIL query_fwd: got r=%0b v=%h expected 1 abcd", bus.query_ready_1, bus.query_val_1);
        end
`else
        n_checks++;
        if (bus.query_ready_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL query_nofwd: got r=%0b expected 0", bus.query_ready_1);
        end
`endif
        n_checks++;
        if (bus.query_ready_2 !== 1'b0) begin
            n_fail++;
            $display("FAIL query_pending0: got r=%0b expected 0", bus.query_ready_2);
        end
        tick();
        bus.cdb_valid   = 1'b0;
        bus.query_tag_2 = tag_t'(9);
        #1;
        n_checks++;
        if ({bus.query_ready_1, bus.query_val_1, bus.query_ready_2, bus.commit_valid} !==
            {1'b1, 32'hABCD, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL query_stored: got r1=%0b v1=%h r2=%0b cv=%0b expected 1 abcd 0 0",
                     bus.query_ready_1, bus.query_val_1, bus.query_ready_2, bus.commit_valid);
        end
    endtask

    task automatic test_rdy_freeze();
        apply_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd8;
        tick();
        idle();
        cdb(0, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        rdy = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bus.commit_valid, bus.issue_tag, bus.rob_empty} !== {1'b0, tag_t'(1), 1'b0}) begin
                n_fail++;
                $display("FAIL rdy_frozen%0d: got cv=%0b tag=%0d empty=%0b expected 0 1 0",
                         i, bus.commit_valid, bus.issue_tag, bus.rob_empty);
            end
        end
        idle();
        rdy = 1'b1;
        tick();
        n_checks++;
        if ({bus.commit_valid, bus.commit_rd, bus.commit_val, bus.commit_tag} !==
            {1'b1, 5'd8, 32'h55, tag_t'(0)}) begin
            n_fail++;
            $display("FAIL rdy_resume_commit: got cv=%0b rd=%0d val=%h tag=%0d expected 1 8 55 0",
                     bus.commit_valid, bus.commit_rd, bus.commit_val, bus.commit_tag);
        end
        tick();
        n_checks++;
        if ({bus.commit_valid, bus.rob_empty, bus.issue_tag} !== {1'b0, 1'b1, tag_t'(1)}) begin
            n_fail++;
            $display("FAIL rdy_drained: got cv=%0b empty=%0b tag=%0d expected 0 1 1",
                     bus.commit_valid, bus.rob_empty, bus.issue_tag);
        end
    endtask

    initial begin
        idle();
        rdy   = 1'b1;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        test_in_order();
        test_reset();
        test_full_wrap();
        test_flush();
        test_query();
        test_rdy_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
